// File: rtl/button_debounce_n_if.sv
// Button debouncer signal bundle: sample tick, raw pins and the debounced outputs.
// master drives tick/btn_in (the system side); slave is the debouncer itself.
interface button_debounce_n_if #(
  parameter int unsigned NCH = 2
) ();

  logic           tick;
  logic [NCH-1:0] btn_in;
  logic [NCH-1:0] level;
  logic [NCH-1:0] press_pulse;
  logic [NCH-1:0] release_pulse;
  logic [NCH-1:0] long_pulse;

  modport master (
    output tick,
    output btn_in,
    input  level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  tick,
    input  btn_in,
    output level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );

endinterface

// File: rtl/button_debounce_n.sv
// Multi-channel button debouncer with press/release edge pulses.
// Each raw pin is polarity-normalised, synchronised through two flops and accepted
// as a new level only after STABLE_CYCLES consecutive ticks of disagreement.
// Optional long-press detection is built when BUTTON_DEBOUNCE_LONGPRESS_EN is defined;
// otherwise long_pulse is tied to 0 and no hold counters exist.
module button_debounce_n #(
  parameter int unsigned NCH           = 2,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_W        = 8,
  parameter int unsigned LONG_CYCLES   = 200
) (
  input logic               clk,
  input logic               rst_n,
  button_debounce_n_if.slave btn_bus
);

  if (NCH < 1 || NCH > 16 ||
      STABLE_CYCLES < 1 || STABLE_CYCLES > (32'd1 << CNT_W) ||
      LONG_CYCLES < 1 || LONG_CYCLES > (32'd1 << LONG_W)) begin : g_bad_param
    $error("button_debounce_n: parameter out of range");
  end

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [NCH-1:0]   pin_norm;
  logic [NCH-1:0]   sync1_q;
  logic [NCH-1:0]   sync_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   level_q, level_d;
  logic [NCH-1:0]   press_q, press_d;
  logic [NCH-1:0]   release_q, release_d;

  assign pin_norm = ACTIVE_LOW ? ~btn_bus.btn_in : btn_bus.btn_in;

  // Two-flop synchroniser on the normalised (1 = pressed) pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= pin_norm;
      sync_q  <= sync1_q;
    end
  end

  // Stability counting: agreement clears the count at once, disagreement counts ticks.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (btn_bus.tick) begin
        // >= rather than == so a corrupted count can never wrap past the limit.
        if (cnt_q[i] >= CntMax) begin
          cnt_d[i]     = '0;
          level_d[i]   = sync_q[i];
          press_d[i]   = sync_q[i];
          release_d[i] = ~sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Counters, debounced level and edge pulses; pulses land together with the level change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_bus.level         = level_q;
  assign btn_bus.press_pulse   = press_q;
  assign btn_bus.release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam logic [LONG_W-1:0] HoldMax = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] hold_q [NCH];
  logic [LONG_W-1:0] hold_d [NCH];
  logic [NCH-1:0]    fired_q, fired_d;
  logic [NCH-1:0]    long_q, long_d;

  // Hold-time counting while pressed; fired_q limits long_pulse to once per press.
  always_comb begin
    fired_d = fired_q;
    long_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      hold_d[i] = hold_q[i];
      if (!level_q[i]) begin
        hold_d[i]  = '0;
        fired_d[i] = 1'b0;
      end else begin
        if (btn_bus.tick && (hold_q[i] < HoldMax)) begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
        if ((hold_q[i] == HoldMax) && !fired_q[i]) begin
          long_d[i]  = 1'b1;
          fired_d[i] = 1'b1;
        end
      end
    end
  end

  // Long-press state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        hold_q[i] <= '0;
      end
      fired_q <= '0;
      long_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        hold_q[i] <= hold_d[i];
      end
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign btn_bus.long_pulse = long_q;
`else
  assign btn_bus.long_pulse = '0;
`endif

endmodule

// File: tb/tb_button_debounce_n.sv
// Scoreboard bench for button_debounce_n (2 channels, STABLE_CYCLES=4, LONG_CYCLES=10).
// Stimulus pushes expected pulse events (clock edge, masks, level); a monitor pops one
// whenever any pulse output is high and compares every field.
module tb_button_debounce_n;

  logic clk;
  logic rst_n;

  button_debounce_n_if #(.NCH(2)) bus ();

  button_debounce_n #(
    .NCH          (2),
    .CNT_W        (4),
    .STABLE_CYCLES(4),
    .ACTIVE_LOW   (1'b1),
    .LONG_W       (8),
    .LONG_CYCLES  (10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_bus(bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [1:0]  press;
    logic [1:0]  rel;
    logic [1:0]  lng;
    logic [1:0]  lvl;
  } ev_t;

  ev_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          div_mode = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [1:0] p, input logic [1:0] r,
                      input logic [1:0] l, input logic [1:0] v);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l; e.lvl = v;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and set tick for the following rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.tick = !div_mode || (((cyc + 1) % 4) == 0);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_level"}, {30'd0, bus.level}, 32'd0);
    check({name, "_press"}, {30'd0, bus.press_pulse}, 32'd0);
    check({name, "_release"}, {30'd0, bus.release_pulse}, 32'd0);
    check({name, "_long"}, {30'd0, bus.long_pulse}, 32'd0);
  endtask

  // Monitor: every pulse cycle must match the oldest expected event.
  always @(negedge clk) begin
    if ((bus.press_pulse | bus.release_pulse | bus.long_pulse) != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {26'd0, bus.press_pulse, bus.release_pulse, bus.long_pulse},
              32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_press", {30'd0, bus.press_pulse}, {30'd0, e.press});
        check("ev_release", {30'd0, bus.release_pulse}, {30'd0, e.rel});
        check("ev_long", {30'd0, bus.long_pulse}, {30'd0, e.lng});
        check("ev_level", {30'd0, bus.level}, {30'd0, e.lvl});
      end
    end
  end

  initial begin
    int unsigned k;
    rst_n      = 1'b0;
    bus.tick   = 1'b1;
    bus.btn_in = 2'b11;
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(5);
    check("idle_level", {30'd0, bus.level}, 32'd0);

    // Clean press on channel 0, held 20 clk, then released.
    step(1);
    k = cyc;
    bus.btn_in = 2'b10;
    push(k + 6, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    push(k + 16, 2'b00, 2'b00, 2'b01, 2'b01);
`endif
    step(5);
    check("t1_level_before", {30'd0, bus.level}, 32'd0);
    step(1);
    check("t1_level_after", {30'd0, bus.level}, 32'd1);
    step(14);
    bus.btn_in = 2'b11;
    push(k + 26, 2'b00, 2'b01, 2'b00, 2'b00);
    step(12);

    // Three-clock glitch: no level change, no pulse.
    k = cyc;
    bus.btn_in = 2'b10;
    step(3);
    bus.btn_in = 2'b11;
    step(8);
    check("t2_glitch_level", {30'd0, bus.level}, 32'd0);

    // Tick on every 4th clock: acceptance on the 4th tick after synchronisation.
    div_mode = 1'b1;
    step(1);
    while ((cyc % 4) != 0) step(1);
    k = cyc;
    bus.btn_in = 2'b10;
    push(k + 16, 2'b01, 2'b00, 2'b00, 2'b01);
    step(15);
    check("t3_level_before", {30'd0, bus.level}, 32'd0);
    step(1);
    check("t3_level_after", {30'd0, bus.level}, 32'd1);
    step(4);
    bus.btn_in = 2'b11;
    push(k + 36, 2'b00, 2'b01, 2'b00, 2'b00);
    step(15);
    check("t3_rel_before", {30'd0, bus.level}, 32'd1);
    step(1);
    check("t3_rel_after", {30'd0, bus.level}, 32'd0);
    div_mode = 1'b0;
    step(6);

    // Both channels pressed and released together.
    k = cyc;
    bus.btn_in = 2'b00;
    push(k + 6, 2'b11, 2'b00, 2'b00, 2'b11);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    push(k + 16, 2'b00, 2'b00, 2'b11, 2'b11);
`endif
    step(20);
    bus.btn_in = 2'b11;
    push(k + 26, 2'b00, 2'b11, 2'b00, 2'b00);
    step(12);

    // Reset at cnt=2 with the button held, then full requalification.
    k = cyc;
    bus.btn_in = 2'b10;
    step(4);
    rst_n = 1'b0;
    step(1);
    check_all_zero("t5_in_reset");
    step(1);
    rst_n = 1'b1;
    push(k + 12, 2'b01, 2'b00, 2'b00, 2'b01);
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    push(k + 22, 2'b00, 2'b00, 2'b01, 2'b01);
`endif
    step(5);
    check("t5_level_before", {30'd0, bus.level}, 32'd0);
    step(1);
    check("t5_level_after", {30'd0, bus.level}, 32'd1);
    step(18);
    bus.btn_in = 2'b11;
    push(k + 36, 2'b00, 2'b01, 2'b00, 2'b00);
    step(12);

    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce_n.md
BUTTON_DEBOUNCE_N -- requirements
Module: button_debounce_n

Interface
REQ-001 The block SHALL have parameter NCH, default 2, number of independent input channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the per-channel stability counter.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 4, consecutive tick samples required to accept a new level (1..2^CNT_W).
REQ-004 The block SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = raw pin low is "pressed".
REQ-005 The block SHALL have parameter LONG_W, default 8, and LONG_CYCLES, default 200, the long-press tick count (1..2^LONG_W).
REQ-006 The block SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 The block SHALL have port tick, input, 1, sample enable; counters advance only in cycles with tick=1.
REQ-009 The block SHALL have port btn_in, input, NCH, raw asynchronous button pins.
REQ-010 The block SHALL have port level, output, NCH, debounced pressed state (1 = pressed), registered.
REQ-011 The block SHALL have port press_pulse, output, NCH, one-clk pulse on a 0->1 level change.
REQ-012 The block SHALL have port release_pulse, output, NCH, one-clk pulse on a 1->0 level change.
REQ-013 The block SHALL have port long_pulse, output, NCH, one-clk long-press pulse (see Configuration).

Function
REQ-014 Each channel SHALL normalise polarity (invert btn_in when ACTIVE_LOW=1) and pass it through a 2-flop synchroniser giving s[i].
REQ-015 Per channel, when s[i]==level[i], cnt[i] SHALL clear to 0 in that cycle, independent of tick.
REQ-016 When s[i]!=level[i] and tick=1 and cnt[i]<STABLE_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-017 When s[i]!=level[i] and tick=1 and cnt[i]==STABLE_CYCLES-1, level[i] SHALL take s[i], cnt[i] SHALL clear, and press_pulse[i] or release_pulse[i] SHALL be 1 in the next cycle only.
REQ-018 When tick=0 and s[i]!=level[i], cnt[i] SHALL hold.
REQ-019 With tick tied high, a clean input change before edge 0 SHALL appear on level after edge 2+STABLE_CYCLES-1; pulses SHALL coincide with the level change.
REQ-020 Any glitch shorter than STABLE_CYCLES ticks SHALL clear cnt[i] and SHALL NOT change level or produce pulses.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 press_pulse[i] and release_pulse[i] SHALL never be 1 together; level SHALL change at most once per STABLE_CYCLES ticks per channel.
REQ-023 cnt SHALL never exceed STABLE_CYCLES-1 (no wrap-around).

Reset
REQ-024 On rst_n=0, synchroniser flops, cnt, hold counters, level, press_pulse, release_pulse and long_pulse SHALL go to 0 asynchronously.
REQ-025 Reset asserted mid-count or mid-press SHALL abort it with no pulse; after release, a held button SHALL be re-qualified from cnt=0 and produce press_pulse.

Configuration
REQ-026 Macro BUTTON_DEBOUNCE_LONGPRESS_EN SHALL control long-press detection.
REQ-027 With the macro defined, each channel SHALL keep hold[i] (LONG_W bits), cleared while level[i]=0, incremented on tick while level[i]=1, saturating at LONG_CYCLES-1.
REQ-028 With the macro defined, long_pulse[i] SHALL be 1 for one clk in the cycle after hold[i] reaches LONG_CYCLES-1, exactly once per press.
REQ-029 Without the macro, hold counters SHALL not be synthesised and long_pulse SHALL be constant 0; the port list SHALL be unchanged.

Verification
REQ-030 Defaults, tick=1, btn_in[0] 1->0 held 20 clk -> level[0]=1 after edge 5, press_pulse[0] one clk, channel 1 unchanged.
REQ-031 btn_in[0] low for 3 clk then high -> level[0] stays 0, no pulses.
REQ-032 tick asserted every 4th clk, STABLE_CYCLES=4 -> level changes after the 4th tick following synchronisation, not before.
REQ-033 Both channels pressed in the same cycle then released together -> simultaneous press_pulse=2'b11, later release_pulse=2'b11.
REQ-034 Macro on, LONG_CYCLES=10, tick=1, hold press 30 clk -> single long_pulse 10 clk after level rises; macro off -> long_pulse stays 0.
REQ-035 rst_n pulsed low at cnt=2 with button held -> all outputs 0, then press_pulse after a full STABLE_CYCLES requalification.
